// File: rtl/ticktocktokens_prog_loader_if.sv
// ticktocktokens_prog_loader_if: programming stream in, config-memory write ports and status out
interface ticktocktokens_prog_loader_if #(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 50,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int PROG_HEADER     = 4,
  parameter int PROG_BITS       = 8
);
  localparam int PW = $clog2(NUM_PROCESSORS);
  localparam int CW = $clog2(NUM_CONNECTIONS);
  logic                       prog_valid;
  logic [PROG_HEADER-1:0]     prog_header;
  logic [PROG_BITS-1:0]       prog_data;
  logic                       proc_we;
  logic [PW-1:0]              proc_addr;
  logic [1:0]                 proc_field;
  logic [PROG_BITS-1:0]       proc_wdata;
  logic                       conn_we;
  logic [CW-1:0]              conn_addr;
  logic [PW-1:0]              conn_src;
  logic [PW-1:0]              conn_tgt;
  logic [NEW_TOKENS_BITS-1:0] conn_tokens;
  logic                       conn_type;
  logic                       run;
  logic                       error;
  logic                       conn_full;
  modport master (
    output prog_valid, prog_header, prog_data,
    input  proc_we, proc_addr, proc_field, proc_wdata,
    input  conn_we, conn_addr, conn_src, conn_tgt, conn_tokens, conn_type,
    input  run, error, conn_full
  );
  modport slave (
    input  prog_valid, prog_header, prog_data,
    output proc_we, proc_addr, proc_field, proc_wdata,
    output conn_we, conn_addr, conn_src, conn_tgt, conn_tokens, conn_type,
    output run, error, conn_full
  );
endinterface

// File: rtl/ticktocktokens_prog_loader.sv
// ticktocktokens_prog_loader: decodes header/data pairs into processor and connection config writes
module ticktocktokens_prog_loader #(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 50,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int TOKENS_BITS     = 8,
  parameter int DURATION_BITS   = 8,
  parameter int PROG_HEADER     = 4,
  parameter int PROG_BITS       = 8
) (
  input logic clock_fast,
  input logic reset,
  ticktocktokens_prog_loader_if.slave bus
);
  localparam int PW = $clog2(NUM_PROCESSORS);
  localparam int CW = $clog2(NUM_CONNECTIONS);
  localparam logic [1:0] IDLE = 2'd0, HAVE_SRC = 2'd1, HAVE_TGT = 2'd2;
  localparam logic [PROG_HEADER-1:0] H_NOP = PROG_HEADER'(0), H_SEL = PROG_HEADER'(1),
    H_GOOD = PROG_HEADER'(2), H_BAD = PROG_HEADER'(3), H_DUR = PROG_HEADER'(4),
    H_PTR = PROG_HEADER'(5), H_SRC = PROG_HEADER'(6), H_TGT = PROG_HEADER'(7),
    H_WEIGHT = PROG_HEADER'(8), H_CTRL = PROG_HEADER'(15);
  localparam logic [PROG_BITS-1:0] NP_L = PROG_BITS'(NUM_PROCESSORS);
  localparam logic [PROG_BITS-1:0] NC_L = PROG_BITS'(NUM_CONNECTIONS);
  localparam logic [PROG_BITS-1:0] TOK_MASK = PROG_BITS'((64'd1 << TOKENS_BITS) - 64'd1);
  localparam logic [PROG_BITS-1:0] DUR_MASK = PROG_BITS'((64'd1 << DURATION_BITS) - 64'd1);
  localparam logic [CW-1:0] LAST = CW'(NUM_CONNECTIONS - 1);

  logic [PROG_HEADER-1:0] hdr;
  logic [PROG_BITS-1:0] dat;
  logic is_cmd, proc_ok;
  logic [PW-1:0] proc_sel_q, proc_sel_d, src_q, src_d, tgt_q, tgt_d;
  logic [CW-1:0] conn_ptr_q, conn_ptr_d;
  logic [1:0] state_q, state_d;
  logic proc_we_q, proc_we_d, conn_we_q, conn_we_d;
  logic [PW-1:0] proc_addr_q, proc_addr_d, conn_src_q, conn_src_d, conn_tgt_q, conn_tgt_d;
  logic [1:0] proc_field_q, proc_field_d;
  logic [PROG_BITS-1:0] proc_wdata_q, proc_wdata_d;
  logic [CW-1:0] conn_addr_q, conn_addr_d;
  logic [NEW_TOKENS_BITS-1:0] conn_tokens_q, conn_tokens_d;
  logic conn_type_q, conn_type_d, run_q, run_d, error_q, error_d, conn_full_q, conn_full_d;

  assign hdr = bus.prog_header;
  assign dat = bus.prog_data;
  assign is_cmd = hdr >= H_SEL && hdr <= H_WEIGHT;
  assign proc_ok = dat < NP_L;

  // Next-state decode: CTRL always honoured, config headers locked out while running
  always_comb begin
    proc_sel_d = proc_sel_q;
    src_d = src_q;
    tgt_d = tgt_q;
    conn_ptr_d = conn_ptr_q;
    state_d = state_q;
    proc_we_d = 1'b0;
    proc_addr_d = proc_addr_q;
    proc_field_d = proc_field_q;
    proc_wdata_d = proc_wdata_q;
    conn_we_d = 1'b0;
    conn_addr_d = conn_addr_q;
    conn_src_d = conn_src_q;
    conn_tgt_d = conn_tgt_q;
    conn_tokens_d = conn_tokens_q;
    conn_type_d = conn_type_q;
    run_d = run_q;
    error_d = error_q;
    conn_full_d = conn_full_q;
    if (bus.prog_valid) begin
      if (hdr == H_CTRL) begin
        run_d = dat[0];
        error_d = error_q & ~dat[1];
      end else if (run_q && is_cmd) begin
        error_d = 1'b1;
      end else begin
        case (hdr)
          H_NOP: ;
          H_SEL: begin
            if (proc_ok) proc_sel_d = dat[PW-1:0];
            else error_d = 1'b1;
          end
          H_GOOD, H_BAD, H_DUR: begin
            proc_we_d = 1'b1;
            proc_addr_d = proc_sel_q;
            proc_field_d = 2'(hdr - H_GOOD);
            proc_wdata_d = dat & (hdr == H_DUR ? DUR_MASK : TOK_MASK);
          end
          H_PTR: begin
            if (dat < NC_L) begin
              conn_ptr_d = dat[CW-1:0];
              conn_full_d = 1'b0;
              state_d = IDLE;
            end else error_d = 1'b1;
          end
          H_SRC: begin
            src_d = proc_ok ? dat[PW-1:0] : src_q;
            state_d = proc_ok ? HAVE_SRC : IDLE;
            error_d = error_q | ~proc_ok;
          end
          H_TGT: begin
            tgt_d = (proc_ok && state_q == HAVE_SRC) ? dat[PW-1:0] : tgt_q;
            state_d = (proc_ok && state_q == HAVE_SRC) ? HAVE_TGT : IDLE;
            error_d = error_q | ~(proc_ok && state_q == HAVE_SRC);
          end
          H_WEIGHT: begin
            state_d = IDLE;
            if (state_q == HAVE_TGT && !conn_full_q) begin
              conn_we_d = 1'b1;
              conn_addr_d = conn_ptr_q;
              conn_src_d = src_q;
              conn_tgt_d = tgt_q;
              conn_tokens_d = dat[NEW_TOKENS_BITS-1:0];
              conn_type_d = dat[NEW_TOKENS_BITS];
              if (conn_ptr_q == LAST) conn_full_d = 1'b1;
              else conn_ptr_d = conn_ptr_q + 1'b1;
            end else error_d = 1'b1;
          end
          default: error_d = 1'b1;
        endcase
      end
    end
  end

  // State and registered outputs; reset wipes partial records and any pending strobe
  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      proc_sel_q <= '0;
      src_q <= '0;
      tgt_q <= '0;
      conn_ptr_q <= '0;
      state_q <= IDLE;
      proc_we_q <= 1'b0;
      proc_addr_q <= '0;
      proc_field_q <= '0;
      proc_wdata_q <= '0;
      conn_we_q <= 1'b0;
      conn_addr_q <= '0;
      conn_src_q <= '0;
      conn_tgt_q <= '0;
      conn_tokens_q <= '0;
      conn_type_q <= 1'b0;
      run_q <= 1'b0;
      error_q <= 1'b0;
      conn_full_q <= 1'b0;
    end else begin
      proc_sel_q <= proc_sel_d;
      src_q <= src_d;
      tgt_q <= tgt_d;
      conn_ptr_q <= conn_ptr_d;
      state_q <= state_d;
      proc_we_q <= proc_we_d;
      proc_addr_q <= proc_addr_d;
      proc_field_q <= proc_field_d;
      proc_wdata_q <= proc_wdata_d;
      conn_we_q <= conn_we_d;
      conn_addr_q <= conn_addr_d;
      conn_src_q <= conn_src_d;
      conn_tgt_q <= conn_tgt_d;
      conn_tokens_q <= conn_tokens_d;
      conn_type_q <= conn_type_d;
      run_q <= run_d;
      error_q <= error_d;
      conn_full_q <= conn_full_d;
    end
  end

  assign bus.proc_we = proc_we_q;
  assign bus.proc_addr = proc_addr_q;
  assign bus.proc_field = proc_field_q;
  assign bus.proc_wdata = proc_wdata_q;
  assign bus.conn_we = conn_we_q;
  assign bus.conn_addr = conn_addr_q;
  assign bus.conn_src = conn_src_q;
  assign bus.conn_tgt = conn_tgt_q;
  assign bus.conn_tokens = conn_tokens_q;
  assign bus.conn_type = conn_type_q;
  assign bus.run = run_q;
  assign bus.error = error_q;
  assign bus.conn_full = conn_full_q;
endmodule
